// File: rtl/lcd_write_engine_pkg.sv
// Shared types and constants for the buffered HD44780 write path.
package lcd_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT} state_t;

  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_SETUP      = 4;
  localparam int DEF_PULSE      = 12;
  localparam int DEF_HOLD       = 4;
  localparam int DEF_EXEC       = 2000;
  localparam int DEF_LONG_EXEC  = 80000;

  localparam int ENTRY_W = 9;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } entry_t;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait
  localparam logic [7:0] CLR_HOME_MASK = 8'hFC;

  function automatic logic is_clr_home(entry_t e);
    return !e.rs && ((e.data & CLR_HOME_MASK) == 8'h00);
  endfunction

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_write_engine_if.sv
// CPU-side write port of the LCD engine: store strobe plus status flags.
interface lcd_write_if;
  logic       wr_en;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       overflow;

  modport master (output wr_en, wr_rs, wr_data, input full, busy, overflow);
  modport slave  (input wr_en, wr_rs, wr_data, output full, busy, overflow);
endinterface

// File: rtl/lcd_write_engine_sync_fifo.sv
// Synchronous FIFO with registered flags; pushes while full are discarded.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_nxt,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Full check uses the registered count, so a same-cycle pop never frees a slot
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/lcd_write_engine.sv
// Buffered HD44780 write engine: FIFO of CPU stores replayed as timed LCD bus cycles.
// Optional LCD_LONG_EXEC_EN: clear/home commands wait LONG_EXEC_CYCLES instead of EXEC_CYCLES.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int SETUP_CYCLES = DEF_SETUP,
  parameter int PULSE_CYCLES = DEF_PULSE,
  parameter int HOLD_CYCLES  = DEF_HOLD,
  parameter int EXEC_CYCLES  = DEF_EXEC
`ifdef LCD_LONG_EXEC_EN
  , parameter int LONG_EXEC_CYCLES = DEF_LONG_EXEC
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  lcd_write_if.slave   bus,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en
);
`ifdef LCD_LONG_EXEC_EN
  localparam int MAX_CYC = max2(max2(max2(SETUP_CYCLES, PULSE_CYCLES), max2(HOLD_CYCLES, EXEC_CYCLES)),
                                LONG_EXEC_CYCLES);
`else
  localparam int MAX_CYC = max2(max2(SETUP_CYCLES, PULSE_CYCLES), max2(HOLD_CYCLES, EXEC_CYCLES));
`endif
  localparam int CW  = $clog2(MAX_CYC + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 busy_q, ovf_q;
  logic                 fifo_full, fifo_empty, pop, idle_nxt;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic [FCW-1:0]       fifo_count, fifo_count_nxt;
  entry_t               head;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.wr_en),
    .wdata     ({bus.wr_rs, bus.wr_data}),
    .pop       (pop),
    .rdata     (fifo_rdata),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head         = entry_t'(fifo_rdata);
  assign pop          = (state == ST_IDLE) && !fifo_empty;
  assign idle_nxt     = ((state == ST_IDLE) && fifo_empty) || ((state == ST_WAIT) && (cnt == '0));
  assign lcd_rw       = 1'b0;
  assign bus.full     = fifo_full;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      busy_q <= (fifo_count_nxt != '0) || !idle_nxt;
      if (bus.wr_en && fifo_full) ovf_q <= 1'b1;
      case (state)
        ST_IDLE: if (!fifo_empty) begin
          lcd_data <= head.data;
          lcd_rs   <= head.rs;
          cnt      <= CW'(SETUP_CYCLES - 1);
          state    <= ST_SETUP;
        end
        ST_SETUP: if (cnt == '0) begin
          cnt    <= CW'(PULSE_CYCLES - 1);
          lcd_en <= 1'b1;
          state  <= ST_PULSE;
        end else cnt <= cnt - 1'b1;
        ST_PULSE: if (cnt == '0) begin
          cnt    <= CW'(HOLD_CYCLES - 1);
          lcd_en <= 1'b0;
          state  <= ST_HOLD;
        end else cnt <= cnt - 1'b1;
        ST_HOLD: if (cnt == '0) begin
`ifdef LCD_LONG_EXEC_EN
          cnt <= is_clr_home({lcd_rs, lcd_data}) ? CW'(LONG_EXEC_CYCLES - 1) : CW'(EXEC_CYCLES - 1);
`else
          cnt <= CW'(EXEC_CYCLES - 1);
`endif
          state <= ST_WAIT;
        end else cnt <= cnt - 1'b1;
        ST_WAIT: if (cnt == '0) state <= ST_IDLE;
                 else cnt <= cnt - 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_write_engine.sv
// Randomized + directed bench for lcd_write_engine against a timeline-based reference model.
module tb_lcd_write_engine;
  localparam int S = 2, P = 3, H = 2, E = 5, DEPTH = 4, LONG = 20;
`ifdef LCD_LONG_EXEC_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en;

  lcd_write_if bus();

  lcd_write_engine #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H), .EXEC_CYCLES(E)
`ifdef LCD_LONG_EXEC_EN
    , .LONG_EXEC_CYCLES(LONG)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  always #5 clk = ~clk;

  // Reference model: each entry is a timeline starting at its pop edge
  int         n_chk = 0, n_fail = 0;
  int         k = 0;
  int         start = -1000;
  int         per = 1 + S + P + H + E;
  logic [8:0] q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_rs = 1'b0;
  bit         m_ovf = 1'b0;

  function automatic int exec_of(logic [8:0] e);
    bit clr_home;
    clr_home = !e[8] && (e[7:2] == 6'd0);
    return (clr_home && LONG_EN) ? LONG : E;
  endfunction

  task automatic model_reset();
    q.delete();
    start  = -1000;
    per    = 1 + S + P + H + E;
    m_data = 8'h00;
    m_rs   = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge();
    int pre;
    logic [8:0] e;
    k++;
    if (!rst_n) return;
    pre = q.size();
    if (pre > 0 && k >= start + per) begin
      e      = q.pop_front();
      start  = k;
      m_data = e[7:0];
      m_rs   = e[8];
      per    = 1 + S + P + H + exec_of(e);
    end
    if (bus.wr_en) begin
      if (pre < DEPTH) q.push_back({bus.wr_rs, bus.wr_data});
      else             m_ovf = 1'b1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic check_all();
    logic en_x, busy_x;
    en_x   = (k >= start + S) && (k < start + S + P);
    busy_x = (q.size() > 0) || (k < start + per - 1);
    chk("lcd_en",   {31'd0, lcd_en},       {31'd0, en_x});
    chk("lcd_data", {24'd0, lcd_data},     {24'd0, m_data});
    chk("lcd_rs",   {31'd0, lcd_rs},       {31'd0, m_rs});
    chk("lcd_rw",   {31'd0, lcd_rw},       32'd0);
    chk("busy",     {31'd0, bus.busy},     {31'd0, busy_x});
    chk("full",     {31'd0, bus.full},     {31'd0, q.size() == DEPTH});
    chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic push(logic rs, logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_rs = rs; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int guard = 0;
    while ((q.size() > 0 || k < start + per) && guard < 2000) begin tick(); guard++; end
    chk("drain_timeout", guard < 2000, 1);
  endtask

  // Asynchronous reset between clock edges; pins must clear without waiting for a clock
  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    idle(2);
    rst_n = 1'b1;
    idle(3);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_rs = 1'b0; bus.wr_data = 8'h00;
    rst_n = 1'b0;
    #1 check_all();
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // single data write
    push(1'b1, 8'h41);
    drain();
    idle(2);

    // back-to-back init sequence
    push(1'b0, 8'h38); push(1'b0, 8'h0C); push(1'b0, 8'h06); push(1'b0, 8'h01);
    drain();

    // overflow: pushes beyond capacity are dropped, flag is sticky
    for (int i = 0; i < 6; i++) push(1'b1, 8'h30 + 8'(i));
    for (int i = 0; i < 3; i++) push(1'b1, 8'h50 + 8'(i));
    drain();
    idle(3);
    async_reset();

    // simultaneous push and pop with three entries queued
    push(1'b1, 8'hA0); push(1'b1, 8'hA1); push(1'b1, 8'hA2); push(1'b1, 8'hA3);
    while (k + 1 < start + per) tick();
    push(1'b1, 8'hA4);
    drain();

    // opcodes that select the long wait only when the feature is present
    push(1'b0, 8'h01); push(1'b0, 8'h80); push(1'b1, 8'h01); push(1'b0, 8'h03);
    drain();

    // reset in the middle of an enable pulse
    push(1'b1, 8'h5A);
    while (!(k >= start + S && k < start + S + P - 1)) tick();
    async_reset();

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      bus.wr_en   = ($urandom_range(0, 5) == 0);
      bus.wr_rs   = 1'($urandom_range(0, 1));
      bus.wr_data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      tick();
      bus.wr_en = 1'b0;
      if (i == 300) async_reset();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
